// File: rtl/byte_serial_adder_pkg.sv
// Shared constants for the byte-serial adder: slice width, FSM encoding, index sizing.
// Imported by the top and the 8-bit slice.
package byte_serial_adder_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_serial_adder_slice.sv
// fwd_adder_8b: combinational 8-bit add with carry in/out.
// Zero latency; no flow control of its own.
module fwd_adder_8b
    import byte_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE_W{1'b0}}, cin_i};

endmodule

// File: rtl/byte_serial_adder.sv
// WIDTH-bit adder computed one byte per cycle through fwd_adder_8b, LSB first.
// Optional signed-overflow output enabled by BYTE_SERIAL_OVF_EN.
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NSLICE = WIDTH / SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef BYTE_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IDX_W = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               cout_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    always_comb begin
        slice_a = a_q[idx_q * SLICE_W +: SLICE_W];
        slice_b = b_q[idx_q * SLICE_W +: SLICE_W];
    end

    fwd_adder_8b u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

`ifdef BYTE_SERIAL_OVF_EN
    logic ovf_q;
    // Carry into the MSB is recovered from the top-byte operand and result bits.
    logic ovf_d;
    assign ovf_d = (slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_sum[SLICE_W-1]) ^ slice_cout;
    assign ovf   = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BYTE_SERIAL_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_q[idx_q * SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_cout;
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
`ifdef BYTE_SERIAL_OVF_EN
                        ovf_q       <= ovf_d;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
